// File: rtl/rat_intr_ctrl.sv
// Eight-source interrupt controller for the RAT MCU: edge-detected pending bits,
// mask, fixed lowest-index priority and a REQ/SERVICE handshake over the port bus.
module rat_intr_ctrl #(
    parameter int          N_SRC   = 8,
    parameter logic [7:0]  MASK_ID = 8'h20,
    parameter logic [7:0]  PEND_ID = 8'h21,
    parameter logic [7:0]  VEC_ID  = 8'h22,
    parameter logic [7:0]  EOI_ID  = 8'h23
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [N_SRC-1:0] IRQ,
    input  logic [7:0]       PORT_ID,
    input  logic [7:0]       OUT_PORT,
    input  logic             IO_STRB,
    input  logic             INTR_ACK,
    output logic             INTR,
    output logic [7:0]       RD_DATA
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [N_SRC-1:0] irq_q;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [2:0]       vec_q, vec_d;
    logic             intr_q;

    logic [N_SRC-1:0] edge_det;
    logic [N_SRC-1:0] w1c;
    logic [N_SRC-1:0] ack_clr;
    logic [7:0]       mask8, pend8, elig8;
    logic [2:0]       win_idx;
    logic             mask_wr, pend_wr, eoi_wr, ack_take;

    assign mask_wr  = IO_STRB && (PORT_ID == MASK_ID);
    assign pend_wr  = IO_STRB && (PORT_ID == PEND_ID);
    assign eoi_wr   = IO_STRB && (PORT_ID == EOI_ID);
    assign edge_det = IRQ & ~irq_q;
    assign w1c      = pend_wr ? OUT_PORT[N_SRC-1:0] : '0;

    // Byte-wide views: sources at or above N_SRC read as zero and never become eligible.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_byte
            if (gi < N_SRC) begin : g_src
                assign mask8[gi] = mask_q[gi];
                assign pend8[gi] = pend_q[gi];
            end else begin : g_pad
                assign mask8[gi] = 1'b0;
                assign pend8[gi] = 1'b0;
            end
        end
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_ack
            assign ack_clr[gi] = ack_take && (vec_q == 3'(gi));
        end
    endgenerate

    assign elig8 = pend8 & mask8;

    always_comb begin
        win_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (elig8[i]) begin
                win_idx = 3'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        ack_take = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|elig8) begin
                    vec_d   = win_idx;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // The latched vector is held; only an ACK or its withdrawal leaves REQ.
                if (INTR_ACK) begin
                    ack_take = 1'b1;
                    state_d  = ST_SERVICE;
                end else if (!elig8[vec_q]) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (eoi_wr) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A new edge outranks any clear of the same bit in the same cycle.
    assign pend_d = (pend_q & ~(w1c | ack_clr)) | edge_det;
    assign mask_d = mask_wr ? OUT_PORT[N_SRC-1:0] : mask_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            irq_q   <= '0;
            mask_q  <= '0;
            pend_q  <= '0;
            vec_q   <= 3'd0;
            state_q <= ST_IDLE;
            intr_q  <= 1'b0;
        end else begin
            irq_q   <= IRQ;
            mask_q  <= mask_d;
            pend_q  <= pend_d;
            vec_q   <= vec_d;
            state_q <= state_d;
            intr_q  <= (state_d == ST_REQ);
        end
    end

    assign INTR = intr_q;

    always_comb begin
        RD_DATA = 8'h00;
        if (PORT_ID == MASK_ID) begin
            RD_DATA = mask8;
        end else if (PORT_ID == PEND_ID) begin
            RD_DATA = pend8;
        end else if (PORT_ID == VEC_ID) begin
            RD_DATA = {state_q == ST_SERVICE, state_q == ST_REQ, 3'b000, vec_q};
        end
    end

endmodule

// File: tb/tb_rat_intr_ctrl.sv
// Directed bench for rat_intr_ctrl: stimulus queues expected INTR/RD_DATA pairs,
// a negedge monitor pops and compares them against the DUT.
module tb_rat_intr_ctrl;

    localparam logic [7:0] MASK_ID = 8'h20;
    localparam logic [7:0] PEND_ID = 8'h21;
    localparam logic [7:0] VEC_ID  = 8'h22;
    localparam logic [7:0] EOI_ID  = 8'h23;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] irq;
    logic [7:0] port_id;
    logic [7:0] out_port;
    logic       io_strb;
    logic       intr_ack;
    logic       intr;
    logic [7:0] rd_data;

    logic       chk_v = 1'b0;
    string      name_q[$];
    logic [8:0] exp_q[$];
    int         checks   = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    rat_intr_ctrl #(.N_SRC(8)) dut (
        .CLK      (clk),
        .RESET_N  (rst_n),
        .IRQ      (irq),
        .PORT_ID  (port_id),
        .OUT_PORT (out_port),
        .IO_STRB  (io_strb),
        .INTR_ACK (intr_ack),
        .INTR     (intr),
        .RD_DATA  (rd_data)
    );

    // Monitor: one expected entry is consumed on every negedge where a sample is flagged.
    always @(negedge clk) begin
        if (chk_v) begin
            if (exp_q.size() == 0) begin
                failures++;
                checks++;
                $display("FAIL monitor: sample flagged with empty expectation queue");
            end else begin
                string      nm;
                logic [8:0] ev;
                nm = name_q.pop_front();
                ev = exp_q.pop_front();
                checks++;
                if (intr !== ev[8]) begin
                    failures++;
                    $display("FAIL %s INTR: got %b expected %b", nm, intr, ev[8]);
                end
                checks++;
                if (rd_data !== ev[7:0]) begin
                    failures++;
                    $display("FAIL %s RD_DATA: got %02h expected %02h", nm, rd_data, ev[7:0]);
                end
                $display("check %-14s port=%02h intr=%b rd=%02h exp_intr=%b exp_rd=%02h",
                         nm, port_id, intr, rd_data, ev[8], ev[7:0]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input logic [7:0] id, input logic e_intr, input logic [7:0] e_data,
                       input string nm);
        port_id = id;
        name_q.push_back(nm);
        exp_q.push_back({e_intr, e_data});
        chk_v = 1'b1;
        step();
        chk_v = 1'b0;
    endtask

    task automatic wr(input logic [7:0] id, input logic [7:0] data);
        port_id  = id;
        out_port = data;
        io_strb  = 1'b1;
        step();
        io_strb  = 1'b0;
        out_port = 8'h00;
        $display("write port=%02h data=%02h", id, data);
    endtask

    task automatic pulse_irq(input logic [7:0] bits);
        irq = bits;
        step();
        irq = 8'h00;
        $display("irq pulse %02h", bits);
    endtask

    task automatic ack();
        intr_ack = 1'b1;
        step();
        intr_ack = 1'b0;
        $display("intr_ack pulse");
    endtask

    initial begin
        rst_n    = 1'b0;
        irq      = 8'h00;
        port_id  = 8'h00;
        out_port = 8'h00;
        io_strb  = 1'b0;
        intr_ack = 1'b0;
        step();

        chk(MASK_ID, 1'b0, 8'h00, "rst_mask");
        chk(PEND_ID, 1'b0, 8'h00, "rst_pend");
        chk(VEC_ID,  1'b0, 8'h00, "rst_vec");
        rst_n = 1'b1;
        step();

        wr(MASK_ID, 8'h01);
        pulse_irq(8'h01);
        chk(VEC_ID,  1'b0, 8'h00, "basic_t");
        chk(VEC_ID,  1'b1, 8'h40, "basic_req");
        chk(PEND_ID, 1'b1, 8'h01, "basic_pend");
        ack();
        chk(PEND_ID, 1'b0, 8'h00, "basic_ackpend");
        chk(VEC_ID,  1'b0, 8'h80, "basic_svc");
        wr(EOI_ID, 8'h5A);
        chk(VEC_ID,  1'b0, 8'h00, "basic_eoi");

        wr(MASK_ID, 8'hFF);
        pulse_irq(8'h28);
        chk(PEND_ID, 1'b0, 8'h28, "prio_pend");
        chk(VEC_ID,  1'b1, 8'h43, "prio_req3");
        ack();
        chk(PEND_ID, 1'b0, 8'h20, "prio_pend20");
        chk(VEC_ID,  1'b0, 8'h83, "prio_svc3");
        wr(EOI_ID, 8'h00);
        chk(VEC_ID,  1'b0, 8'h03, "prio_idle");
        chk(VEC_ID,  1'b1, 8'h45, "prio_req5");
        ack();
        chk(PEND_ID, 1'b0, 8'h00, "prio_pend00");
        wr(EOI_ID, 8'h00);
        chk(VEC_ID,  1'b0, 8'h05, "prio_done");

        wr(MASK_ID, 8'h00);
        pulse_irq(8'h04);
        chk(PEND_ID, 1'b0, 8'h04, "mpend_pend");
        chk(VEC_ID,  1'b0, 8'h05, "mpend_idle");
        wr(MASK_ID, 8'h04);
        chk(VEC_ID,  1'b0, 8'h05, "mpend_m0");
        chk(VEC_ID,  1'b1, 8'h42, "mpend_req");
        chk(MASK_ID, 1'b1, 8'h04, "mpend_mask");

        wr(PEND_ID, 8'h04);
        chk(VEC_ID,  1'b1, 8'h42, "wd_w");
        chk(VEC_ID,  1'b0, 8'h02, "wd_idle");
        chk(PEND_ID, 1'b0, 8'h00, "wd_pend");

        pulse_irq(8'h04);
        chk(VEC_ID,  1'b0, 8'h02, "coll_t");
        chk(VEC_ID,  1'b1, 8'h42, "coll_req");
        irq      = 8'h04;
        intr_ack = 1'b1;
        step();
        irq      = 8'h00;
        intr_ack = 1'b0;
        $display("intr_ack with irq edge 04");
        chk(PEND_ID, 1'b0, 8'h04, "coll_pend");
        chk(VEC_ID,  1'b0, 8'h82, "coll_svc");

        wr(PEND_ID, 8'h04);
        pulse_irq(8'h10);
        chk(PEND_ID, 1'b0, 8'h10, "mid_pend");
        chk(VEC_ID,  1'b0, 8'h82, "mid_svc");
        rst_n = 1'b0;
        chk(MASK_ID, 1'b0, 8'h00, "mid_rst_mask");
        chk(PEND_ID, 1'b0, 8'h00, "mid_rst_pend");
        chk(VEC_ID,  1'b0, 8'h00, "mid_rst_vec");
        rst_n = 1'b1;
        step();
        pulse_irq(8'h10);
        chk(PEND_ID, 1'b0, 8'h10, "post_pend");
        chk(VEC_ID,  1'b0, 8'h00, "post_idle1");
        chk(VEC_ID,  1'b0, 8'h00, "post_idle2");

        step();
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard: %0d expectations never sampled", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
